prompt_string_decoder: RTL and testbench

Reader/decoder for the packed prompt string built by the game's string generator and input registers. It latches a 64-bit right-aligned, prefix-coded symbol string and strips leading zeros. It then parses the variable-length codes MSB-first and plays each symbol on the 3-bit prompt output, holding it for a fixed number of tick strobes. It sits between the string generator and the LED prompt outputs, driven by the game control FSM via start/done.

---
 rtl/prompt_string_decoder_pkg.sv | 29 ++
 rtl/prompt_string_decoder_symbol_timer.sv | 42 ++++
 rtl/prompt_string_decoder.sv | 169 ++++++++++++++++
 tb/tb_prompt_string_decoder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prompt_string_decoder_pkg.sv
// Shared types and constants for the prompt string decoder: FSM states,
// symbol codes and the limits of the prefix code.
package prompt_string_decoder_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    PARSE = 3'd2,
    SHOW  = 3'd3,
    GAP   = 3'd4,
    ERROR = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam logic [2:0] SYM_NONE   = 3'd0;
  localparam logic [2:0] SYM_TOGGLE = 3'd1;
  localparam logic [2:0] SYM_PUSH   = 3'd2;
  localparam logic [2:0] SYM_MIC    = 3'd3;
  localparam logic [2:0] SYM_MOUSE  = 3'd4;

  localparam int MAX_CODE_ONES = 4;
  localparam int TICK_CNT_W    = 4;

  // True for the states in which a playback run is in progress.
  function automatic logic state_is_busy(state_t s);
    return (s == ALIGN) || (s == PARSE) || (s == SHOW) || (s == GAP) || (s == ERROR);
  endfunction

endpackage

// File: rtl/prompt_string_decoder_symbol_timer.sv
// Counts tick strobes from zero up to load_val and flags the strobe that
// reaches it; shared by the symbol display and the blank gap phases.
module symbol_timer
  import prompt_string_decoder_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  tick,
  input  logic [TICK_CNT_W-1:0] load_val,
  output logic                  expire
);

  logic [TICK_CNT_W-1:0] count_q;
  logic [TICK_CNT_W-1:0] count_d;
  logic [TICK_CNT_W-1:0] count_inc;

  assign count_inc = count_q + TICK_CNT_W'(1);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && tick) begin
      count_d = count_inc;
    end
  end

  // A strobe in the first cycle after a clear already counts, because
  // count_q is zero in that cycle and the strobe lands on count_inc.
  assign expire = enable && tick && (count_inc == load_val);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/prompt_string_decoder.sv
// Latches a right-aligned, prefix-coded symbol string, strips leading zeros,
// then decodes codes MSB-first and plays each symbol on prompt for a fixed
// number of tick strobes, with a blank gap between symbols.
module prompt_string_decoder
  import prompt_string_decoder_pkg::*;
#(
  parameter int WIDTH         = 64,
  parameter int DISPLAY_TICKS = 2,
  parameter int GAP_TICKS     = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] bstring,
  input  logic             tick,
  output logic [2:0]       prompt,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [5:0]       sym_count,
  output state_t           dbg_state
);

  // Handshake: start is a single-cycle request honoured only in IDLE; busy
  // rises the cycle after an accepted start and falls in the DONE cycle,
  // where done pulses for exactly one cycle and error is valid with it.

  localparam int BL_W = $clog2(WIDTH + 1);

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      shreg_q, shreg_d;
  logic [BL_W-1:0]       bits_left_q, bits_left_d;
  logic [2:0]            ones_q, ones_d;
  logic [2:0]            symbol_q, symbol_d;
  logic [5:0]            sym_count_q, sym_count_d;
  logic                  error_q, error_d;
  logic [2:0]            prompt_q, prompt_d;

  logic                  msb;
  logic                  timer_clear;
  logic                  timer_enable;
  logic                  timer_expire;
  logic [TICK_CNT_W-1:0] timer_load;

  assign msb = shreg_q[WIDTH-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bits_left_q <= '0;
      ones_q      <= '0;
      symbol_q    <= SYM_NONE;
      sym_count_q <= '0;
      error_q     <= 1'b0;
      prompt_q    <= SYM_NONE;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bits_left_q <= bits_left_d;
      ones_q      <= ones_d;
      symbol_q    <= symbol_d;
      sym_count_q <= sym_count_d;
      error_q     <= error_d;
      prompt_q    <= prompt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = ALIGN;
      end
      ALIGN: begin
        if (bits_left_q == '0) state_d = DONE;
        else if (msb)          state_d = PARSE;
      end
      PARSE: begin
        // Running out of bits mid-code means the string was truncated.
        if (bits_left_q == '0) begin
          state_d = (ones_q != '0) ? ERROR : DONE;
        end else if (msb) begin
          if (ones_q == 3'(MAX_CODE_ONES)) state_d = ERROR;
        end else begin
          state_d = (ones_q == '0) ? ERROR : SHOW;
        end
      end
      SHOW: begin
        if (timer_expire) state_d = (GAP_TICKS == 0) ? PARSE : GAP;
      end
      GAP: begin
        if (timer_expire) state_d = PARSE;
      end
      ERROR:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shreg_d     = shreg_q;
    bits_left_d = bits_left_q;
    ones_d      = ones_q;
    symbol_d    = symbol_q;
    sym_count_d = sym_count_q;
    error_d     = error_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d     = bstring;
          bits_left_d = BL_W'(WIDTH);
          ones_d      = '0;
          sym_count_d = '0;
          error_d     = 1'b0;
        end
      end
      ALIGN: begin
        if ((bits_left_q != '0) && !msb) begin
          shreg_d     = shreg_q << 1;
          bits_left_d = bits_left_q - BL_W'(1);
        end
      end
      PARSE: begin
        if (bits_left_q != '0) begin
          shreg_d     = shreg_q << 1;
          bits_left_d = bits_left_q - BL_W'(1);
          if (msb) begin
            ones_d = ones_q + 3'd1;
          end else if (ones_q != '0) begin
            symbol_d    = ones_q;
            ones_d      = '0;
            sym_count_d = sym_count_q + 6'd1;
          end
        end
      end
      default: ;
    endcase
    if (state_d == ERROR) error_d = 1'b1;
  end

  // prompt is registered from the next state so it lines up with SHOW.
  assign prompt_d = (state_d == SHOW) ? symbol_d : SYM_NONE;

  assign timer_clear  = (state_d != state_q);
  assign timer_enable = (state_q == SHOW) || (state_q == GAP);
  assign timer_load   = (state_q == SHOW) ? TICK_CNT_W'(DISPLAY_TICKS)
                                          : TICK_CNT_W'(GAP_TICKS);

  symbol_timer u_symbol_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (timer_clear),
    .enable   (timer_enable),
    .tick     (tick),
    .load_val (timer_load),
    .expire   (timer_expire)
  );

  always_comb begin
    busy      = state_is_busy(state_q);
    done      = (state_q == DONE);
    error     = error_q;
    prompt    = prompt_q;
    sym_count = sym_count_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_prompt_string_decoder.sv
// Directed bench for prompt_string_decoder: a string-level model predicts the
// symbol list and error flag, and a monitor checks prompt/busy/done each cycle.
module tb_prompt_string_decoder;
  import prompt_string_decoder_pkg::*;

  localparam int WIDTH         = 64;
  localparam int DISPLAY_TICKS = 2;
  localparam int GAP_TICKS     = 1;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] bstring;
  logic             tick;
  logic [2:0]       prompt;
  logic             busy;
  logic             done;
  logic             error;
  logic [5:0]       sym_count;
  state_t           dbg_state;

  int total = 0;
  int bad   = 0;

  logic [2:0] exp_q[$];
  int         exp_cnt;
  logic       exp_err;

  logic       run_active = 1'b0;
  logic       tick_en    = 1'b0;
  int         done_seen  = 0;
  logic       done_err;
  logic [5:0] done_cnt;
  int         shown      = 0;
  int         hold_ticks = 0;
  int         gap_ticks  = 0;
  logic [2:0] prev_prompt = 3'd0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  prompt_string_decoder #(
    .WIDTH(WIDTH), .DISPLAY_TICKS(DISPLAY_TICKS), .GAP_TICKS(GAP_TICKS)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .bstring(bstring), .tick(tick),
    .prompt(prompt), .busy(busy), .done(done), .error(error),
    .sym_count(sym_count), .dbg_state(dbg_state)
  );

  // Tick strobe every 4 clocks once enabled.
  initial begin
    int div;
    div  = 0;
    tick = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      tick = tick_en && (div == 3);
      div  = (div + 1) % 4;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  // Walk the string MSB-first from its first one: runs of ones closed by a
  // zero are symbols; a lone zero, a run longer than four, or a run cut off
  // by the end of the string is malformed.
  task automatic model_parse(input logic [WIDTH-1:0] s);
    int   ones;
    logic stop;
    logic started;
    exp_q.delete();
    exp_err = 1'b0;
    ones    = 0;
    stop    = 1'b0;
    started = 1'b0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      if (!stop && (started || s[k])) begin
        started = 1'b1;
        if (s[k]) begin
          ones++;
          if (ones > MAX_CODE_ONES) begin exp_err = 1'b1; stop = 1'b1; end
        end else if (ones == 0) begin
          exp_err = 1'b1;
          stop    = 1'b1;
        end else begin
          exp_q.push_back(3'(ones));
          ones = 0;
        end
      end
    end
    if (!stop && ones > 0) exp_err = 1'b1;
    exp_cnt = exp_q.size();
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clock) begin
    if (reset) begin
      prev_prompt = 3'd0;
    end else if (!run_active) begin
      check("idle_done", done, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("idle_prompt", prompt, 3'd0);
      prev_prompt = 3'd0;
    end else begin
      check("busy", busy, done ? 1'b0 : 1'b1);
      if (prompt != 3'd0) begin
        if (prompt != prev_prompt) begin
          if (prev_prompt != 3'd0) check("hold_ticks", hold_ticks, DISPLAY_TICKS);
          if (shown > 0 && prev_prompt == 3'd0) check("gap_ticks", gap_ticks >= GAP_TICKS, 1'b1);
          if (exp_q.size() == 0) check("extra_symbol", prompt, 3'd0);
          else check("symbol", prompt, exp_q.pop_front());
          shown++;
          check("sym_count_live", sym_count, shown);
          hold_ticks = 0;
        end
        if (tick) hold_ticks++;
      end else begin
        if (prev_prompt != 3'd0) begin
          check("hold_ticks", hold_ticks, DISPLAY_TICKS);
          gap_ticks = 0;
        end
        if (tick) gap_ticks++;
      end
      if (done) begin
        check("done_error", error, exp_err);
        check("done_count", sym_count, exp_cnt);
        check("leftover_symbols", exp_q.size(), 0);
        done_err   = error;
        done_cnt   = sym_count;
        done_seen++;
        run_active = 1'b0;
      end
      prev_prompt = prompt;
    end
  end

  // ---------------- drivers ----------------
  task automatic launch(input logic [WIDTH-1:0] s);
    model_parse(s);
    shown     = 0;
    done_seen = 0;
    @(posedge clock);
    #1;
    bstring = s;
    start   = 1'b1;
    @(posedge clock);
    #1;
    start      = 1'b0;
    run_active = 1'b1;
  endtask

  task automatic run_string(input string name, input logic [WIDTH-1:0] s,
                            input logic lit_err, input int lit_cnt,
                            input int budget, input logic poke_start,
                            output int cycles);
    launch(s);
    cycles = 0;
    while (done_seen == 0 && cycles < budget) begin
      @(negedge clock);
      #2;
      cycles++;
      if (poke_start && cycles == 20) begin
        bstring = 64'h3E;
        start   = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
      end
    end
    check({name, "_done_once"}, done_seen, 1);
    if (done_seen == 0) run_active = 1'b0;
    check({name, "_lit_error"}, done_err, lit_err);
    check({name, "_lit_count"}, done_cnt, lit_cnt);
    repeat (3) @(negedge clock);
    #2;
    check({name, "_error_held"}, error, lit_err);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    reset   = 1'b1;
    start   = 1'b0;
    bstring = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_prompt", prompt, 3'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_count", sym_count, 6'd0);
    check("rst_state", dbg_state, IDLE);
    @(posedge clock);
    #1;
    reset   = 1'b0;
    tick_en = 1'b1;

    // Pin the model with hand-decoded strings.
    model_parse(64'h2E);
    check("model_2e_n", exp_q.size(), 2);
    check("model_2e_s0", exp_q[0], 3'd1);
    check("model_2e_s1", exp_q[1], 3'd3);
    check("model_2e_err", exp_err, 1'b0);
    model_parse(64'h2DDE);
    check("model_2dde_n", exp_q.size(), 4);
    check("model_2dde_s3", exp_q[3], 3'd4);
    model_parse(64'h4);
    check("model_4_n", exp_q.size(), 1);
    check("model_4_err", exp_err, 1'b1);
    model_parse(64'h7);
    check("model_7_err", exp_err, 1'b1);

    run_string("two_syms", 64'h2E, 1'b0, 2, 400, 1'b0, cyc);
    run_string("empty", 64'h0, 1'b0, 0, 200, 1'b0, cyc);
    check("empty_latency_le_66", cyc <= 66, 1'b1);
    run_string("five_ones", 64'h3E, 1'b1, 0, 200, 1'b0, cyc);
    run_string("stray_zero", 64'h4, 1'b1, 1, 400, 1'b0, cyc);
    run_string("truncated", 64'h7, 1'b1, 0, 200, 1'b0, cyc);
    run_string("all_four", 64'h2DDE, 1'b0, 4, 600, 1'b0, cyc);
    run_string("max_syms", 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 32, 3000, 1'b1, cyc);

    // Reset while the first symbol is on display.
    launch(64'h2E);
    cyc = 0;
    while (prompt == 3'd0 && cyc < 100) begin
      @(negedge clock);
      #2;
      cyc++;
    end
    check("rst_mid_reached_show", prompt, 3'd1);
    #1;
    reset      = 1'b1;
    run_active = 1'b0;
    #1;
    check("rst_mid_prompt", prompt, 3'd0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_count", sym_count, 6'd0);
    check("rst_mid_state", dbg_state, IDLE);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (30) @(negedge clock);
    #2;
    check("rst_mid_no_done", done_seen, 0);
    run_string("replay", 64'h2E, 1'b0, 2, 400, 1'b0, cyc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
